// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback stage with EFLAGS merge and 2-entry skid queue to the register file.
//   clk, reset (sync, active-high), flush (drops queue, keeps EFLAGS)
//   in_valid/in_ready, alu_out, alu_flags, flag_mask, dest_reg, reg_we : ALU side
//   out_valid/out_ready, out_data, out_dest, out_we                    : register-file side
//   eflags : architectural EFLAGS
//   stall_cnt : saturating count of cycles with in_valid=1 and in_ready=0,
//               present only when ALU_WB_STALL_CNT_EN is defined
module alu_wb_stage #(
   parameter int          DEPTH      = 2,
   parameter logic [31:0] FLAG_WMASK = 32'hCD5,
   parameter logic [31:0] EFLAGS_RST = 32'h2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_out,
   input  logic [31:0] alu_flags,
   input  logic [31:0] flag_mask,
   input  logic [2:0]  dest_reg,
   input  logic        reg_we,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [2:0]  out_dest,
   output logic        out_we,
`ifdef ALU_WB_STALL_CNT_EN
   output logic [15:0] stall_cnt,
`endif
   output logic [31:0] eflags
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'(DEPTH)} state_t;
   state_t      state, state_nxt;
   logic [31:0] head_data, tail_data, flag_m, eflags_nxt;
   logic [2:0]  head_dest, tail_dest;
   logic        head_we, tail_we;
   logic        push, pop, load_head, load_tail, shift;
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign out_data  = out_valid ? head_data : 32'd0;
   assign out_dest  = out_valid ? head_dest : 3'd0;
   assign out_we    = out_valid & head_we;
   assign flag_m     = flag_mask & FLAG_WMASK;
   // Bit 1 of EFLAGS is architecturally 1; all non-writable bits read 0.
   assign eflags_nxt = (((eflags & ~flag_m) | (alu_flags & flag_m)) & FLAG_WMASK) | 32'h2;
   always_comb begin
      state_nxt = flush             ? EMPTY :
                  (state == EMPTY)  ? (push ? ONE : EMPTY) :
                  (state == ONE)    ? ((push & ~pop) ? FULL : (pop & ~push) ? EMPTY : ONE) :
                                      (pop ? ONE : FULL);
      // A push into an empty queue, or a push that coincides with the head
      // leaving, lands directly in the head slot.
      load_head = push & ((state == EMPTY) | pop);
      load_tail = push & ~pop & (state == ONE);
      shift     = pop & (state == FULL);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         head_data <= 32'd0;
         head_dest <= 3'd0;
         head_we   <= 1'b0;
         tail_data <= 32'd0;
         tail_dest <= 3'd0;
         tail_we   <= 1'b0;
         eflags    <= EFLAGS_RST;
      end else begin
         state <= state_nxt;
         if (load_head) begin
            head_data <= alu_out;
            head_dest <= dest_reg;
            head_we   <= reg_we;
         end else if (shift) begin
            head_data <= tail_data;
            head_dest <= tail_dest;
            head_we   <= tail_we;
         end
         if (load_tail) begin
            tail_data <= alu_out;
            tail_dest <= dest_reg;
            tail_we   <= reg_we;
         end
         if (push)
            eflags <= eflags_nxt;
      end
   end
`ifdef ALU_WB_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= 16'd0;
      else if (in_valid & ~in_ready & ~&stall_cnt)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule
